game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter NUM_GHOSTS, default 4, number of ghost position channels.
REQ-002 SHALL have parameter NUM_FRUITS, default 4, number of fruit pickup slots.
REQ-003 SHALL have parameter START_LIVES, default 3, lives loaded at restart.
REQ-004 SHALL have parameter HIT_TOL, default 2, pixel overlap tolerance.
REQ-005 SHALL have parameter SCORE_W, default 16, score width; FRUIT_PTS, default 50, points per fruit.
REQ-006 SHALL have parameter HOLD_FRAMES, default 60, respawn hold length in frames.
REQ-007 Clk  in  1  sole clock.
REQ-008 Reset  in  1  asynchronous active-high reset.
REQ-009 keycode  in  8  keyboard code; 8'h28 = start, 8'h13 = pause toggle.
REQ-010 frame_tick  in  1  one-cycle pulse per video frame.
REQ-011 time_up  in  1  level timer expired.
REQ-012 dots_clear  in  1  all dots eaten.
REQ-013 pX, pY  in  10 each  PacMan centre; pSize, gSize, fSize  in  10 each  half-extents.
REQ-014 gX, gY  in  10*NUM_GHOSTS each  packed ghost centres, ghost i at [10i+9:10i].
REQ-015 fX, fY  in  10*NUM_FRUITS each  packed fruit centres.
REQ-016 state  out  4  current state code from package.
REQ-017 win, lose, pause, lifeDown  out  1 each  status flags.
REQ-018 lives  out  4; score  out  SCORE_W; fruits_eaten  out  NUM_FRUITS; ghost_hit  out  NUM_GHOSTS.

Function
REQ-019 SHALL implement states RESTART, IDLE, RUN, PAUSED, LIFE_LOST, RESPAWN, GAME_OVER, GAME_WON.
REQ-020 RESTART SHALL load lives=START_LIVES, score=0, fruits_eaten=0, then go to IDLE next cycle.
REQ-021 IDLE SHALL assert pause and go to RUN on keycode==8'h28.
REQ-022 RUN SHALL evaluate in priority: time_up -> GAME_OVER; dots_clear -> GAME_WON; any ghost overlap -> LIFE_LOST; pause key edge -> PAUSED.
REQ-023 Overlap for ghost i SHALL be |pX-gX| <= pSize+gSize+HIT_TOL and |pY-gY| <= pSize+gSize+HIT_TOL, computed in 11-bit unsigned magnitude, no wrap.
REQ-024 ghost_hit SHALL be the combinational per-ghost overlap vector in all states.
REQ-025 In RUN, uneaten fruit j overlapping PacMan (fSize in place of gSize) SHALL set fruits_eaten[j] and add FRUIT_PTS next cycle; multiple fruits same cycle each score.
REQ-026 Score SHALL saturate at all-ones, never wrap.
REQ-027 Pause key SHALL be edge-detected: action only on cycle keycode changes to 8'h13; holding it has no further effect.
REQ-028 PAUSED SHALL assert pause, freeze score/lives, return to RUN on next pause-key edge.
REQ-029 LIFE_LOST SHALL last exactly one cycle, decrement lives, assert lifeDown; go to GAME_OVER if lives was 1, else RESPAWN.
REQ-030 RESPAWN SHALL assert lifeDown, count HOLD_FRAMES frame_tick pulses, then go to RUN only if ghost_hit==0, else keep holding.
REQ-031 GAME_OVER asserts lose and pause; GAME_WON asserts win and pause; both return to RESTART on keycode==8'h28.
REQ-032 Ghost overlap and fruit overlap in same RUN cycle: ghost wins, fruit not scored.

Reset
REQ-033 Reset SHALL force state RESTART, lives=START_LIVES, score=0, fruits_eaten=0, hold counter 0, key-edge register 0, all flags 0.
REQ-034 Reset asserted mid-RESPAWN or mid-PAUSED SHALL abandon the operation with no residual counter value.

Configuration
REQ-035 Macro GAME_CTRL_POWER_EN SHALL enable power mode: input power_pellet starts a 360-frame frightened window; ghost overlap then scores 200 and sets ghost_eaten[i] instead of LIFE_LOST.
REQ-036 Without GAME_CTRL_POWER_EN, power_pellet and ghost_eaten ports SHALL not exist and ghost overlap always loses a life.

Structure
REQ-037 Package game_pkg SHALL hold the state enum, key codes 8'h28/8'h13, and point constants.
REQ-038 Sub-module box_overlap (one instance per ghost and per fruit via generate) SHALL compute REQ-023.

Verification
REQ-039 Reset, keycode 8'h28 -> IDLE then RUN, lives=3, score=0.
REQ-040 In RUN, pX=pY=100, gX[1]=gY[1]=105, sizes 6 -> LIFE_LOST one cycle, lives=2, RESPAWN.
REQ-041 Lives=1, ghost overlap -> LIFE_LOST then GAME_OVER, lose=1, pause=1.
REQ-042 PacMan on fruits 0 and 2 simultaneously -> fruits_eaten=4'b0101, score=100; re-entry adds nothing.
REQ-043 Hold 8'h13 for 10 cycles -> PAUSED once; second press -> RUN.
REQ-044 score preset near max, fruit eaten -> score stays 16'hFFFF.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the maze game controller: state codes, key codes,
// point values and the per-state status flag decode.
package game_pkg;

  localparam int unsigned COORD_W = 10;

  typedef enum logic [3:0] {
    ST_RESTART   = 4'd0,
    ST_IDLE      = 4'd1,
    ST_RUN       = 4'd2,
    ST_PAUSED    = 4'd3,
    ST_LIFE_LOST = 4'd4,
    ST_RESPAWN   = 4'd5,
    ST_GAME_OVER = 4'd6,
    ST_GAME_WON  = 4'd7
  } state_e;

  localparam logic [7:0] KEY_START = 8'h28;
  localparam logic [7:0] KEY_PAUSE = 8'h13;

  localparam int unsigned DEF_FRUIT_PTS = 50;
  localparam int unsigned GHOST_PTS     = 200;
  localparam int unsigned FRIGHT_FRAMES = 360;

  typedef struct packed {
    logic win;
    logic lose;
    logic pause;
    logic life_down;
  } flags_t;

  // Status flags implied by a state.
  function automatic flags_t state_flags(input state_e s);
    flags_t f;
    f = '0;
    case (s)
      ST_IDLE, ST_PAUSED:       f.pause = 1'b1;
      ST_LIFE_LOST, ST_RESPAWN: f.life_down = 1'b1;
      ST_GAME_OVER: begin
        f.lose  = 1'b1;
        f.pause = 1'b1;
      end
      ST_GAME_WON: begin
        f.win   = 1'b1;
        f.pause = 1'b1;
      end
      default: ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Axis-aligned box overlap test between two centred boxes.
// Ports: a_*_i / b_*_i centre and half-extent of each box,
//        hit_c_o combinational overlap result.
module box_overlap
  import game_pkg::*;
#(
  parameter int unsigned TOL = 2
) (
  input  logic [COORD_W-1:0] a_x_i,
  input  logic [COORD_W-1:0] a_y_i,
  input  logic [COORD_W-1:0] a_size_i,
  input  logic [COORD_W-1:0] b_x_i,
  input  logic [COORD_W-1:0] b_y_i,
  input  logic [COORD_W-1:0] b_size_i,
  output logic               hit_c_o
);

  localparam int unsigned MAG_W = COORD_W + 1;
  // Limit gets one extra bit so size+size+tolerance can never wrap.
  localparam int unsigned LIM_W = COORD_W + 2;

  logic [MAG_W-1:0] dx;
  logic [MAG_W-1:0] dy;
  logic [LIM_W-1:0] lim;

  // Absolute distances and overlap limit.
  always_comb begin
    dx = (a_x_i >= b_x_i) ? (MAG_W'(a_x_i) - MAG_W'(b_x_i))
                          : (MAG_W'(b_x_i) - MAG_W'(a_x_i));
    dy = (a_y_i >= b_y_i) ? (MAG_W'(a_y_i) - MAG_W'(b_y_i))
                          : (MAG_W'(b_y_i) - MAG_W'(a_y_i));
    lim = LIM_W'(a_size_i) + LIM_W'(b_size_i) + LIM_W'(TOL);
    hit_c_o = (LIM_W'(dx) <= lim) && (LIM_W'(dy) <= lim);
  end

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: start/pause handling, ghost collisions, lives,
// fruit pickups with saturating score, respawn hold.
// Ports: Clk/Reset (async, active high); keycode, frame_tick, time_up,
//        dots_clear, PacMan/ghost/fruit geometry in; state, status flags,
//        lives, score, fruits_eaten out; ghost_hit is the live overlap vector.
// Optional GAME_CTRL_POWER_EN: adds power_pellet in / ghost_eaten out; a
//        pellet opens a frightened window in which ghosts are eaten for points.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_GHOSTS  = 4,
  parameter int unsigned NUM_FRUITS  = 4,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned HIT_TOL     = 2,
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned FRUIT_PTS   = DEF_FRUIT_PTS,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [7:0]                    keycode,
  input  logic                          frame_tick,
  input  logic                          time_up,
  input  logic                          dots_clear,
  input  logic [COORD_W-1:0]            pX,
  input  logic [COORD_W-1:0]            pY,
  input  logic [COORD_W-1:0]            pSize,
  input  logic [COORD_W-1:0]            gSize,
  input  logic [COORD_W-1:0]            fSize,
  input  logic [COORD_W*NUM_GHOSTS-1:0] gX,
  input  logic [COORD_W*NUM_GHOSTS-1:0] gY,
  input  logic [COORD_W*NUM_FRUITS-1:0] fX,
  input  logic [COORD_W*NUM_FRUITS-1:0] fY,
`ifdef GAME_CTRL_POWER_EN
  input  logic                          power_pellet,
  output logic [NUM_GHOSTS-1:0]         ghost_eaten,
`endif
  output logic [3:0]                    state,
  output logic                          win,
  output logic                          lose,
  output logic                          pause,
  output logic                          lifeDown,
  output logic [3:0]                    lives,
  output logic [SCORE_W-1:0]            score,
  output logic [NUM_FRUITS-1:0]         fruits_eaten,
  output logic [NUM_GHOSTS-1:0]         ghost_hit
);

  localparam int unsigned HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);
  localparam int unsigned SUM_W = SCORE_W + 32;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_e                state_q, state_d;
  logic [3:0]            lives_q, lives_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [SCORE_W-1:0]    score_acc;
  logic [NUM_FRUITS-1:0] fruits_q, fruits_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  key_q;
  flags_t                flags_q;

  logic                  key_pause_c;
  logic                  pause_edge_c;
  logic                  lethal_c;
  logic [NUM_FRUITS-1:0] fruit_hit;

`ifdef GAME_CTRL_POWER_EN
  localparam int unsigned FRIGHT_W = $clog2(FRIGHT_FRAMES + 1);
  logic [FRIGHT_W-1:0]   fright_q, fright_d;
  logic [NUM_GHOSTS-1:0] eaten_q, eaten_d;
`endif

  // Adds points, clamping at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input int unsigned b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum > SUM_W'(SCORE_MAX)) return SCORE_MAX;
    return SCORE_W'(sum);
  endfunction

  // One overlap checker per ghost.
  for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
    box_overlap #(.TOL(HIT_TOL)) u_ovl (
      .a_x_i   (pX),
      .a_y_i   (pY),
      .a_size_i(pSize),
      .b_x_i   (gX[COORD_W*gi +: COORD_W]),
      .b_y_i   (gY[COORD_W*gi +: COORD_W]),
      .b_size_i(gSize),
      .hit_c_o (ghost_hit[gi])
    );
  end

  // One overlap checker per fruit.
  for (genvar fi = 0; fi < NUM_FRUITS; fi++) begin : g_fruit
    box_overlap #(.TOL(HIT_TOL)) u_ovl (
      .a_x_i   (pX),
      .a_y_i   (pY),
      .a_size_i(pSize),
      .b_x_i   (fX[COORD_W*fi +: COORD_W]),
      .b_y_i   (fY[COORD_W*fi +: COORD_W]),
      .b_size_i(fSize),
      .hit_c_o (fruit_hit[fi])
    );
  end

  // Pause acts only on the cycle the key code first becomes the pause code.
  assign key_pause_c  = (keycode == KEY_PAUSE);
  assign pause_edge_c = key_pause_c & ~key_q;

`ifdef GAME_CTRL_POWER_EN
  // While frightened, touching a ghost eats it rather than costing a life.
  assign lethal_c = (|ghost_hit) && (fright_q == '0);
`else
  assign lethal_c = |ghost_hit;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    score_acc = score_q;
    fruits_d  = fruits_q;
    hold_d    = '0;
`ifdef GAME_CTRL_POWER_EN
    fright_d = fright_q;
    eaten_d  = eaten_q;
    if (power_pellet) begin
      fright_d = FRIGHT_W'(FRIGHT_FRAMES);
    end else if (frame_tick && (fright_q != '0)) begin
      fright_d = fright_q - FRIGHT_W'(1);
    end
    if (fright_q == '0) eaten_d = '0;
`endif

    case (state_q)
      ST_RESTART: begin
        lives_d  = 4'(START_LIVES);
        score_d  = '0;
        fruits_d = '0;
`ifdef GAME_CTRL_POWER_EN
        fright_d = '0;
        eaten_d  = '0;
`endif
        state_d  = ST_IDLE;
      end

      ST_IDLE: begin
        if (keycode == KEY_START) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (time_up)           state_d = ST_GAME_OVER;
        else if (dots_clear)   state_d = ST_GAME_WON;
        else if (lethal_c)     state_d = ST_LIFE_LOST;
        else if (pause_edge_c) state_d = ST_PAUSED;

        // A lethal ghost touch pre-empts any pickup in the same cycle.
        if (!lethal_c) begin
          for (int j = 0; j < NUM_FRUITS; j++) begin
            if (fruit_hit[j] && !fruits_q[j]) begin
              fruits_d[j] = 1'b1;
              score_acc   = sat_add(score_acc, FRUIT_PTS);
            end
          end
        end
`ifdef GAME_CTRL_POWER_EN
        if (fright_q != '0) begin
          for (int i = 0; i < NUM_GHOSTS; i++) begin
            if (ghost_hit[i] && !eaten_q[i]) begin
              eaten_d[i] = 1'b1;
              score_acc  = sat_add(score_acc, GHOST_PTS);
            end
          end
        end
`endif
        score_d = score_acc;
      end

      ST_PAUSED: begin
        if (pause_edge_c) state_d = ST_RUN;
      end

      ST_LIFE_LOST: begin
        lives_d = (lives_q != 4'd0) ? (lives_q - 4'd1) : 4'd0;
        state_d = (lives_q <= 4'd1) ? ST_GAME_OVER : ST_RESPAWN;
      end

      // Hold for a fixed number of frames, then wait for a clear spawn point.
      ST_RESPAWN: begin
        hold_d = hold_q;
        if (hold_q >= HOLD_MAX) begin
          if (ghost_hit == '0) begin
            state_d = ST_RUN;
            hold_d  = '0;
          end
        end else if (frame_tick) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      ST_GAME_OVER, ST_GAME_WON: begin
        if (keycode == KEY_START) state_d = ST_RESTART;
      end

      default: state_d = ST_RESTART;
    endcase
  end

  // State and datapath registers; flags are decoded from the next state so
  // they line up with the state output.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_RESTART;
      lives_q  <= 4'(START_LIVES);
      score_q  <= '0;
      fruits_q <= '0;
      hold_q   <= '0;
      key_q    <= 1'b0;
      flags_q  <= '0;
`ifdef GAME_CTRL_POWER_EN
      fright_q <= '0;
      eaten_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      fruits_q <= fruits_d;
      hold_q   <= hold_d;
      key_q    <= key_pause_c;
      flags_q  <= state_flags(state_d);
`ifdef GAME_CTRL_POWER_EN
      fright_q <= fright_d;
      eaten_q  <= eaten_d;
`endif
    end
  end

  assign state        = state_q;
  assign win          = flags_q.win;
  assign lose         = flags_q.lose;
  assign pause        = flags_q.pause;
  assign lifeDown     = flags_q.life_down;
  assign lives        = lives_q;
  assign score        = score_q;
  assign fruits_eaten = fruits_q;
`ifdef GAME_CTRL_POWER_EN
  assign ghost_eaten  = eaten_q;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl.
module tb_game_ctrl;

  localparam int NG = 4;
  localparam int NF = 6;
  localparam int SW = 8;

  localparam logic [3:0] S_RESTART = 4'd0;
  localparam logic [3:0] S_IDLE    = 4'd1;
  localparam logic [3:0] S_RUN     = 4'd2;
  localparam logic [3:0] S_PAUSED  = 4'd3;
  localparam logic [3:0] S_LOST    = 4'd4;
  localparam logic [3:0] S_RESPAWN = 4'd5;
  localparam logic [3:0] S_OVER    = 4'd6;
  localparam logic [3:0] S_WON     = 4'd7;

  logic            Clk;
  logic            Reset;
  logic [7:0]      keycode;
  logic            frame_tick, time_up, dots_clear;
  logic [9:0]      pX, pY, pSize, gSize, fSize;
  logic [10*NG-1:0] gX, gY;
  logic [10*NF-1:0] fX, fY;
  logic [3:0]      state;
  logic            win, lose, pause, lifeDown;
  logic [3:0]      lives;
  logic [SW-1:0]   score;
  logic [NF-1:0]   fruits_eaten;
  logic [NG-1:0]   ghost_hit;
`ifdef GAME_CTRL_POWER_EN
  logic            power_pellet;
  logic [NG-1:0]   ghost_eaten;
`endif

  int checks = 0;
  int errors = 0;

  game_ctrl #(
    .NUM_GHOSTS (NG),
    .NUM_FRUITS (NF),
    .SCORE_W    (SW),
    .HOLD_FRAMES(3)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .frame_tick  (frame_tick),
    .time_up     (time_up),
    .dots_clear  (dots_clear),
    .pX          (pX),
    .pY          (pY),
    .pSize       (pSize),
    .gSize       (gSize),
    .fSize       (fSize),
    .gX          (gX),
    .gY          (gY),
    .fX          (fX),
    .fY          (fY),
`ifdef GAME_CTRL_POWER_EN
    .power_pellet(power_pellet),
    .ghost_eaten (ghost_eaten),
`endif
    .state       (state),
    .win         (win),
    .lose        (lose),
    .pause       (pause),
    .lifeDown    (lifeDown),
    .lives       (lives),
    .score       (score),
    .fruits_eaten(fruits_eaten),
    .ghost_hit   (ghost_hit)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  task automatic set_ghost(input int i, input int x, input int y);
    gX[10*i +: 10] = 10'(x);
    gY[10*i +: 10] = 10'(y);
  endtask

  task automatic set_fruit(input int i, input int x, input int y);
    fX[10*i +: 10] = 10'(x);
    fY[10*i +: 10] = 10'(y);
  endtask

  task automatic press_start();
    keycode = 8'h28;
    tick();
    keycode = 8'h00;
  endtask

  initial begin
    Reset = 1'b1; keycode = 8'h00; frame_tick = 1'b0; time_up = 1'b0; dots_clear = 1'b0;
    pX = 10'd100; pY = 10'd100; pSize = 10'd6; gSize = 10'd6; fSize = 10'd6;
    gX = '0; gY = '0; fX = '0; fY = '0;
`ifdef GAME_CTRL_POWER_EN
    power_pellet = 1'b0;
`endif
    for (int i = 0; i < NG; i++) set_ghost(i, 800, 800);
    for (int i = 0; i < NF; i++) set_fruit(i, 600, 600);
    repeat (2) tick();

    // Reset state
    chk("rst_state", 32'(state), 32'(S_RESTART));
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_fruits", 32'(fruits_eaten), 32'd0);
    chk("rst_flags", 32'({win, lose, pause, lifeDown}), 32'd0);

    Reset = 1'b0;
    tick();
    chk("idle_state", 32'(state), 32'(S_IDLE));
    chk("idle_pause", 32'(pause), 32'd1);
    press_start();
    chk("run_state", 32'(state), 32'(S_RUN));
    chk("run_pause", 32'(pause), 32'd0);
    chk("run_lives", 32'(lives), 32'd3);
    chk("run_score", 32'(score), 32'd0);

    // Two fruits in one cycle
    set_fruit(0, 100, 100);
    set_fruit(2, 104, 98);
    tick();
    chk("fruit02_mask", 32'(fruits_eaten), 32'b000101);
    chk("fruit02_score", 32'(score), 32'd100);
    tick();
    chk("fruit_reentry", 32'(score), 32'd100);
    set_fruit(1, 103, 100);
    tick();
    chk("fruit1_score", 32'(score), 32'd150);
    set_fruit(3, 90, 110);
    tick();
    chk("fruit3_score", 32'(score), 32'd200);
    set_fruit(4, 100, 104);
    tick();
    chk("fruit4_score", 32'(score), 32'd250);
    set_fruit(5, 96, 100);
    tick();
    chk("score_sat", 32'(score), 32'hFF);
    chk("fruit_all", 32'(fruits_eaten), 32'b111111);
    tick();
    chk("score_sat_hold", 32'(score), 32'hFF);
    for (int i = 0; i < NF; i++) set_fruit(i, 600, 600);

    // Held pause key toggles only once
    keycode = 8'h13;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_held", 32'(state), 32'(S_PAUSED));
    end
    chk("paused_flag", 32'(pause), 32'd1);
    keycode = 8'h00;
    tick();
    chk("paused_release", 32'(state), 32'(S_PAUSED));
    keycode = 8'h13;
    tick();
    chk("unpause", 32'(state), 32'(S_RUN));
    chk("unpause_flag", 32'(pause), 32'd0);
    keycode = 8'h00;

    // First ghost hit; ghost still present after hold
    set_ghost(1, 105, 105);
    #1;
    chk("ghost_hit_vec", 32'(ghost_hit), 32'b0010);
    tick();
    chk("lost1_state", 32'(state), 32'(S_LOST));
    chk("lost1_flag", 32'(lifeDown), 32'd1);
    tick();
    chk("respawn1_state", 32'(state), 32'(S_RESPAWN));
    chk("respawn1_lives", 32'(lives), 32'd2);
    chk("respawn1_flag", 32'(lifeDown), 32'd1);
    repeat (3) pulse();
    tick();
    chk("respawn_blocked", 32'(state), 32'(S_RESPAWN));
    set_ghost(1, 800, 800);
    tick();
    chk("respawn1_exit", 32'(state), 32'(S_RUN));
    chk("respawn1_exit_flag", 32'(lifeDown), 32'd0);

    // Second hit; exact hold length
    set_ghost(1, 105, 105);
    tick();
    chk("lost2_state", 32'(state), 32'(S_LOST));
    set_ghost(1, 800, 800);
    tick();
    chk("respawn2_lives", 32'(lives), 32'd1);
    repeat (2) pulse();
    chk("hold_2_frames", 32'(state), 32'(S_RESPAWN));
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("hold_3rd_frame", 32'(state), 32'(S_RESPAWN));
    tick();
    chk("hold_done", 32'(state), 32'(S_RUN));

    // Last life
    set_ghost(1, 105, 105);
    tick();
    chk("lost3_state", 32'(state), 32'(S_LOST));
    tick();
    chk("over_state", 32'(state), 32'(S_OVER));
    chk("over_flags", 32'({win, lose, pause, lifeDown}), 32'b0110);
    chk("over_lives", 32'(lives), 32'd0);
    set_ghost(1, 800, 800);

    // Overlap boundaries: limit is 6+6+2 = 14
    set_ghost(0, 114, 100); #1;
    chk("edge_x_plus14", 32'(ghost_hit), 32'b0001);
    set_ghost(0, 115, 100); #1;
    chk("edge_x_plus15", 32'(ghost_hit), 32'b0000);
    set_ghost(0, 86, 100); #1;
    chk("edge_x_minus14", 32'(ghost_hit), 32'b0001);
    set_ghost(0, 85, 100); #1;
    chk("edge_x_minus15", 32'(ghost_hit), 32'b0000);
    set_ghost(0, 100, 115); #1;
    chk("edge_y_plus15", 32'(ghost_hit), 32'b0000);
    set_ghost(0, 800, 800);

    // Restart from game over
    press_start();
    chk("restart_state", 32'(state), 32'(S_RESTART));
    tick();
    chk("restart_idle", 32'(state), 32'(S_IDLE));
    chk("restart_lives", 32'(lives), 32'd3);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_fruits", 32'(fruits_eaten), 32'd0);

    // Ghost and fruit in the same cycle: ghost wins
    set_fruit(0, 100, 100);
    set_ghost(1, 105, 105);
    press_start();
    tick();
    chk("gf_state", 32'(state), 32'(S_LOST));
    chk("gf_fruits", 32'(fruits_eaten), 32'd0);
    chk("gf_score", 32'(score), 32'd0);
    set_fruit(0, 600, 600);
    set_ghost(1, 800, 800);
    tick();
    repeat (3) pulse();
    chk("gf_back_run", 32'(state), 32'(S_RUN));

    // time_up outranks dots_clear
    time_up = 1'b1;
    dots_clear = 1'b1;
    tick();
    time_up = 1'b0;
    dots_clear = 1'b0;
    chk("timeup_prio", 32'(state), 32'(S_OVER));
    press_start();
    tick();
    press_start();
    chk("run_again", 32'(state), 32'(S_RUN));
    dots_clear = 1'b1;
    tick();
    dots_clear = 1'b0;
    chk("won_state", 32'(state), 32'(S_WON));
    chk("won_flags", 32'({win, lose, pause, lifeDown}), 32'b1010);

    // Reset in the middle of a respawn hold
    press_start();
    tick();
    press_start();
    set_ghost(1, 105, 105);
    tick();
    set_ghost(1, 800, 800);
    tick();
    repeat (2) pulse();
    Reset = 1'b1;
    #1;
    chk("mid_rst_state", 32'(state), 32'(S_RESTART));
    chk("mid_rst_lives", 32'(lives), 32'd3);
    chk("mid_rst_flag", 32'(lifeDown), 32'd0);
    tick();
    Reset = 1'b0;
    tick();
    press_start();
    set_ghost(1, 105, 105);
    tick();
    set_ghost(1, 800, 800);
    tick();
    chk("rst_respawn", 32'(state), 32'(S_RESPAWN));
    repeat (2) pulse();
    chk("no_residual_hold", 32'(state), 32'(S_RESPAWN));
    pulse();
    chk("fresh_hold_done", 32'(state), 32'(S_RUN));

    // Reset while paused
    keycode = 8'h13;
    tick();
    chk("pause_again", 32'(state), 32'(S_PAUSED));
    Reset = 1'b1;
    #1;
    chk("rst_paused_state", 32'(state), 32'(S_RESTART));
    chk("rst_paused_flag", 32'(pause), 32'd0);
    keycode = 8'h00;
    tick();
    Reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
